cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer.sv | 99 +++++++++
 tb/tb_cpu_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetches one word per instruction from a combinational ROM,
// decodes it for a register file/ALU, and handles start, single-step and halt control.
module cpu_sequencer #(
    parameter int PC_W = 6,
    parameter int IW   = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step_mode,
    input  logic            step,
    input  logic [IW-1:0]   instr,
    output logic [PC_W-1:0] pc,
    output logic            reg_we,
    output logic [1:0]      dst,
    output logic [2:0]      op,
    output logic [1:0]      src_a,
    output logic [1:0]      src_b,
    output logic            running,
    output logic            halted,
    output logic            err,
    output logic [7:0]      retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_PAUSE,
        S_HALT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] ir;
    logic          legal;

    assign dst     = ir[8:7];
    assign op      = ir[6:4];
    assign src_a   = ir[3:2];
    assign src_b   = ir[1:0];
    assign legal   = (ir[6:4] != 3'b011) && (ir[6:4] != 3'b110) && (ir[6:4] != 3'b111);
    assign running = (state == S_FETCH) || (state == S_EXEC) || (state == S_PAUSE);
    assign halted  = (state == S_HALT);

    always_comb begin
        state_nx = state;
        reg_we   = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nx = step_mode ? S_PAUSE : S_FETCH;
            S_FETCH: state_nx = S_EXEC;
            S_EXEC: begin
                reg_we = ir[9] && legal;
                if (ir[10])         state_nx = S_HALT;
                else if (step_mode) state_nx = S_PAUSE;
                else                state_nx = S_FETCH;
            end
            S_PAUSE: if (step || !step_mode) state_nx = S_FETCH;
            S_HALT:  if (start) state_nx = step_mode ? S_PAUSE : S_FETCH;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            err     <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc      <= '0;
                        retired <= '0;
                    end
                end
                S_FETCH: ir <= instr;
                S_EXEC: begin
                    // Illegal opcodes still retire and advance; they only raise the sticky flag.
                    pc <= pc + PC_W'(1);
                    if (retired != 8'hFF) retired <= retired + 8'd1;
                    if (!legal) err <= 1'b1;
                end
                S_HALT: begin
                    if (start) begin
                        pc      <= '0;
                        retired <= '0;
                        err     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: single-instruction vector table, directed
// control sequences, and random programs checked against a program-level model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [10:0] instr;
    logic [5:0]  pc;
    logic        reg_we;
    logic [1:0]  dst;
    logic [2:0]  op;
    logic [1:0]  src_a;
    logic [1:0]  src_b;
    logic        running;
    logic        halted;
    logic        err;
    logic [7:0]  retired;

    logic [10:0] rom [64];
    assign instr = rom[pc];

    cpu_sequencer #(.PC_W(6), .IW(11)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
        .instr(instr), .pc(pc), .reg_we(reg_we), .dst(dst), .op(op),
        .src_a(src_a), .src_b(src_b), .running(running), .halted(halted),
        .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    int         exp_n;
    logic       exp_err;

    typedef struct {
        logic [10:0] word;
        logic        we;
        logic        e;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; step = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic bit op_legal(input logic [2:0] o);
        return o inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    // Program-level model: walk the ROM from 0 until the halt bit, collecting expected writes.
    task automatic build_expect();
        exp_q.delete();
        exp_n = 0;
        exp_err = 1'b0;
        for (int i = 0; i < 64; i++) begin
            logic [10:0] w;
            w = rom[i];
            exp_n++;
            if (!op_legal(w[6:4])) exp_err = 1'b1;
            else if (w[9]) exp_q.push_back(w[8:0]);
            if (w[10]) break;
        end
    endtask

    // Called right after the edge that sampled start; counts that edge as edge 1.
    task automatic run_to_halt(output int edges, output int pulses, output int bad_gap);
        int last;
        edges = 1; pulses = 0; bad_gap = 0; last = 0;
        while (!halted && edges < 400) begin
            tick();
            edges++;
            if (reg_we) begin
                if ((pulses == 0 && edges != 2) || (pulses > 0 && edges - last != 2)) bad_gap++;
                last = edges;
                pulses++;
                if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
                else chk("we_fields", int'({dst, op, src_a, src_b}), int'(exp_q.pop_front()));
            end
        end
        if (!halted) chk("halt_timeout", 0, 1);
    endtask

    task automatic load_fib();
        for (int i = 0; i < 64; i++) rom[i] = 11'h0;
        for (int i = 0; i < 31; i++) begin
            logic [1:0] d, a, b;
            d = 2'(i); a = 2'(i + 2); b = 2'(i + 3);
            rom[i] = {(i == 30) ? 1'b1 : 1'b0, 1'b1, d, 3'b000, a, b};
        end
    endtask

    initial begin
        vec_t vt[10];
        int edges, pulses, gaps, cnt;

        vt[0] = '{11'b0_1_01_011_00_00, 1'b0, 1'b1};
        vt[1] = '{11'b0_0_00_000_00_00, 1'b0, 1'b0};
        vt[2] = '{11'b0_1_10_000_01_11, 1'b1, 1'b0};
        vt[3] = '{11'b0_1_11_001_10_01, 1'b1, 1'b0};
        vt[4] = '{11'b0_1_00_010_11_10, 1'b1, 1'b0};
        vt[5] = '{11'b0_1_01_100_00_01, 1'b1, 1'b0};
        vt[6] = '{11'b0_1_10_101_01_00, 1'b1, 1'b0};
        vt[7] = '{11'b0_1_11_110_11_11, 1'b0, 1'b1};
        vt[8] = '{11'b0_1_00_111_10_10, 1'b0, 1'b1};
        vt[9] = '{11'b0_0_11_101_00_00, 1'b0, 1'b0};

        for (int i = 0; i < 64; i++) rom[i] = 11'h0;

        // Reset idle: nothing moves without start.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_pc", pc, 0);
            chk("idle_flags", {reg_we, running, halted, err}, 0);
            chk("idle_retired", retired, 0);
        end

        // Single-instruction table followed by a non-writing halt word.
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 64; i++) rom[i] = 11'h0;
            rom[0] = vt[v].word;
            rom[1] = 11'h400;
            do_reset();
            pulse_start();
            tick();
            chk($sformatf("v%0d_we", v), reg_we, vt[v].we);
            chk($sformatf("v%0d_fields", v), {dst, op, src_a, src_b}, vt[v].word[8:0]);
            tick();
            chk($sformatf("v%0d_pc1", v), pc, 1);
            chk($sformatf("v%0d_ret1", v), retired, 1);
            chk($sformatf("v%0d_err", v), err, vt[v].e);
            chk($sformatf("v%0d_we_off", v), reg_we, 0);
            chk($sformatf("v%0d_hold", v), {dst, op, src_a, src_b}, vt[v].word[8:0]);
            tick(); tick();
            chk($sformatf("v%0d_halted", v), {halted, running}, 2'b10);
            chk($sformatf("v%0d_pc2", v), pc, 2);
            chk($sformatf("v%0d_ret2", v), retired, 2);
        end

        // Fibonacci-style program, then restart from HALT and re-run.
        load_fib();
        build_expect();
        do_reset();
        pulse_start();
        run_to_halt(edges, pulses, gaps);
        chk("fib_halt_edge", edges, 1 + 2 * exp_n);
        chk("fib_pulses", pulses, 31);
        chk("fib_gaps", gaps, 0);
        chk("fib_pc", pc, 31);
        chk("fib_retired", retired, 31);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("halt_frozen", {pc, reg_we, halted}, {6'd31, 1'b0, 1'b1});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_pc", pc, 0);
        chk("restart_ret", retired, 0);
        chk("restart_state", {running, halted, err}, 3'b100);
        build_expect();
        run_to_halt(edges, pulses, gaps);
        chk("rerun_edge", edges, 1 + 2 * exp_n);
        chk("rerun_pulses", pulses, 31);
        chk("rerun_pc", pc, 31);

        // Reset during EXEC of the 5th instruction.
        do_reset();
        pulse_start();
        for (int c = 0; c < 9; c++) tick();
        chk("mid_exec_we", {reg_we, pc}, {1'b1, 6'd4});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_pc", pc, 0);
        chk("rst_ret", retired, 0);
        chk("rst_flags", {reg_we, running, halted}, 0);

        // Start is ignored while running.
        pulse_start();
        tick();
        start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        chk("start_ignored_pc", pc, 2);

        // Single-step: three step pulses five cycles apart.
        do_reset();
        step_mode = 1'b1;
        pulse_start();
        cnt = 0;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            if (reg_we) cnt++;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (reg_we) cnt++;
            end
        end
        chk("step_pulses", cnt, 3);
        chk("step_pc", pc, 3);
        chk("step_state", {running, halted}, 2'b10);
        tick(); tick();
        chk("step_hold", {pc, reg_we}, {6'd3, 1'b0});
        step_mode = 1'b0;
        tick(); tick();
        chk("step_release", reg_we, 1);

        // Endless program: pc wraps and retired saturates.
        for (int i = 0; i < 64; i++) rom[i] = 11'h0;
        do_reset();
        pulse_start();
        for (int c = 0; c < 128; c++) tick();
        chk("wrap_pc", pc, 64 % 64);
        chk("wrap_ret", retired, 64);
        for (int c = 0; c < 472; c++) tick();
        chk("sat_pc", pc, 300 % 64);
        chk("sat_ret", retired, 255);
        chk("sat_flags", {running, halted, err}, 3'b100);

        // Random programs against the model.
        for (int t = 0; t < 20; t++) begin
            int h;
            h = $urandom_range(1, 40);
            for (int i = 0; i < 64; i++) rom[i] = 11'($urandom) & 11'h3FF;
            rom[h] = 11'($urandom) | 11'h400;
            build_expect();
            do_reset();
            pulse_start();
            run_to_halt(edges, pulses, gaps);
            chk("rnd_edge", edges, 1 + 2 * (h + 1));
            chk("rnd_left", exp_q.size(), 0);
            chk("rnd_pc", pc, h + 1);
            chk("rnd_ret", retired, h + 1);
            chk("rnd_err", err, exp_err);
            if (exp_err) begin
                pulse_start();
                chk("rnd_err_clear", err, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
